// File: rtl/multicycle_pkg.sv
// Shared encodings for the multi-cycle RISC-V control FSM: states, opcodes,
// ALU operation codes, datapath mux selects and the immediate-format decoder.
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_ADR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALU_WB,
    S_JALR_ADR,
    S_JAL,
    S_BRANCH,
    S_LUI,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  localparam logic [2:0] IMM_I    = 3'b000;
  localparam logic [2:0] IMM_S    = 3'b001;
  localparam logic [2:0] IMM_B    = 3'b010;
  localparam logic [2:0] IMM_J    = 3'b011;
  localparam logic [2:0] IMM_U    = 3'b100;
  localparam logic [2:0] IMM_NONE = 3'b000;

  function automatic logic [2:0] imm_decode(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_ITYPE, OP_JALR: imm_decode = IMM_I;
      OP_STORE:                   imm_decode = IMM_S;
      OP_BRANCH:                  imm_decode = IMM_B;
      OP_JAL:                     imm_decode = IMM_J;
      OP_LUI:                     imm_decode = IMM_U;
      default:                    imm_decode = IMM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_branch_cond.sv
// Branch resolution from funct3 and the ALU subtract flags.
module branch_cond (
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       lt,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = !zero;
      3'b100:  taken = lt;
      3'b101:  taken = !lt;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle RISC-V core: sequences fetch, decode,
// execute, memory and writeback, and counts retired instructions.
//
// state      | meaning
// FETCH      | read instruction at PC, PC += 4 on mem_ready
// DECODE     | alu_out <= old_pc + imm, dispatch on opcode
// MEM_ADR    | alu_out <= rs1 + imm
// MEM_READ   | load request at alu_out
// MEM_WB     | write load data to rd
// MEM_WRITE  | store request at alu_out
// EXEC_R     | R-type ALU operation
// EXEC_I     | I-type ALU operation
// ALU_WB     | write alu_out to rd
// JALR_ADR   | alu_out <= rs1 + imm
// JAL        | PC <= alu_out, alu_out <= old_pc + 4
// BRANCH     | compare rs1/rs2, PC <= target if taken
// LUI        | write imm to rd
// TRAP       | unsupported opcode, held until reset
module multicycle_controller
  import multicycle_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 zero,
  input  logic                 lt,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_write,
  output logic                 adr_src,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 reg_write,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           aluop,
  output logic [1:0]           result_src,
  output logic [2:0]           imm_src,
  output logic                 illegal,
  output logic [INSTRET_W-1:0] instret
);

  state_t                 state;
  state_t                 state_next;
  logic                   taken;
  logic [INSTRET_W-1:0]   instret_count;

  branch_cond u_branch_cond (
    .funct3 (funct3),
    .zero   (zero),
    .lt     (lt),
    .taken  (taken)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_FETCH;
      instret_count <= '0;
    end else begin
      state <= state_next;
      if (state_next == S_FETCH && state != S_FETCH)
        instret_count <= instret_count + INSTRET_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    aluop      = ALUOP_ADD;
    result_src = RES_ALUOUT;
    imm_src    = imm_decode(opcode);
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (opcode)
          OP_RTYPE:          state_next = S_EXEC_R;
          OP_ITYPE:          state_next = S_EXEC_I;
          OP_LOAD, OP_STORE: state_next = S_MEM_ADR;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          OP_JALR:           state_next = S_JALR_ADR;
          OP_LUI:            state_next = S_LUI;
          default:           state_next = S_TRAP;
        endcase
      end
      S_MEM_ADR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        state_next = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        result_src = RES_MEM;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) state_next = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        aluop      = ALUOP_RTYPE;
        state_next = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        aluop      = ALUOP_ITYPE;
        state_next = S_ALU_WB;
      end
      S_ALU_WB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_JALR_ADR: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_IMM;
        state_next = S_JAL;
      end
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALUOUT;
        pc_write   = 1'b1;
        state_next = S_ALU_WB;
      end
      S_BRANCH: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        aluop      = ALUOP_SUB;
        result_src = RES_ALUOUT;
        pc_write   = taken;
        state_next = S_FETCH;
      end
      S_LUI: begin
        result_src = RES_IMM;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_TRAP: begin
        illegal = 1'b1;
        imm_src = IMM_NONE;
      end
      default: state_next = S_FETCH;
    endcase
    // Outputs are held quiet for the whole reset cycle, even mid memory wait.
    if (!rst_n) begin
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      aluop      = 2'b00;
      result_src = 2'b00;
      imm_src    = 3'b000;
      illegal    = 1'b0;
    end
  end

  assign instret = rst_n ? instret_count : '0;

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control FSM for the multi-cycle RISC-V core. Sequences each instruction through fetch, decode, execute, memory and writeback. Drives the shared ALU's `aluop` (consumed by the ALU control decoder), the datapath mux selects, and register/memory/PC enables. Handles memory wait states and counts retired instructions.

## Interface
- `INSTRET_W`, default 32: width of the retired-instruction counter.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `opcode` in 7: `instr[6:0]` from the instruction register.
- `funct3` in 3: `instr[14:12]`.
- `zero` in 1: ALU result equals 0.
- `lt` in 1: ALU signed less-than flag, valid during subtract.
- `mem_ready` in 1: memory completes the current request this cycle.
- `mem_req` out 1: memory access request.
- `mem_write` out 1: the request is a store.
- `adr_src` out 1: memory address select; 0 = PC, 1 = `alu_out` register.
- `ir_write` out 1: load the instruction register and `old_pc`.
- `pc_write` out 1: load PC from the result bus.
- `reg_write` out 1: register file write enable.
- `alu_src_a` out 2: ALU A select; 00 = PC, 01 = `old_pc`, 10 = rs1.
- `alu_src_b` out 2: ALU B select; 00 = rs2, 01 = imm, 10 = constant 4.
- `aluop` out 2: 00 = add, 01 = sub, 10 = R-type decode, 11 = I-type decode.
- `result_src` out 2: result bus select; 00 = `alu_out` register, 01 = memory data, 10 = ALU result, 11 = imm.
- `imm_src` out 3: immediate format; I = 000, S = 001, B = 010, J = 011, U = 100.
- `illegal` out 1: unsupported opcode trapped.
- `instret` out `INSTRET_W`: count of retired instructions.

## Operation
- Moore-style FSM; outputs are decoded combinationally from state, with these exceptions:
  - FETCH, MEM_READ and MEM_WRITE qualify on `mem_ready`.
  - BRANCH `pc_write` depends on `zero` and `lt`.
- Any output not listed for a state is 0.
- `imm_src` is decoded from `opcode` in every state:
  - 0000011, 0010011, 1100111 give I.
  - 0100011 gives S.
  - 1100011 gives B.
  - 1101111 gives J.
  - 0110111 gives U.
  - Anything else gives 000.
- Per-state outputs and next state:
  - FETCH: `mem_req`=1, `adr_src`=0, a=00, b=10, aluop=00, result_src=10. If `mem_ready`: `ir_write`=1, `pc_write`=1, go to DECODE. Otherwise stay.
  - DECODE: a=01, b=01, aluop=00, which latches `old_pc`+imm into `alu_out`. Next state by opcode:
    - 0110011 to EXEC_R.
    - 0010011 to EXEC_I.
    - 0000011 and 0100011 to MEM_ADR.
    - 1100011 to BRANCH.
    - 1101111 to JAL.
    - 1100111 to JALR_ADR.
    - 0110111 to LUI.
    - Any other opcode to TRAP.
  - MEM_ADR: a=10, b=01, aluop=00. Go to MEM_READ if opcode is 0000011, else MEM_WRITE.
  - MEM_READ: `mem_req`=1, `adr_src`=1. Go to MEM_WB on `mem_ready`.
  - MEM_WB: result_src=01, `reg_write`=1. Go to FETCH.
  - MEM_WRITE: `mem_req`=1, `mem_write`=1, `adr_src`=1. Go to FETCH on `mem_ready`.
  - EXEC_R: a=10, b=00, aluop=10. Go to ALU_WB.
  - EXEC_I: a=10, b=01, aluop=11. Go to ALU_WB.
  - ALU_WB: result_src=00, `reg_write`=1. Go to FETCH.
  - JALR_ADR: a=10, b=01, aluop=00, which latches rs1+imm into `alu_out`. Go to JAL.
  - JAL: a=01, b=10, aluop=00, result_src=00, `pc_write`=1. PC takes the target from `alu_out`; `alu_out` takes `old_pc`+4. Go to ALU_WB.
  - BRANCH: a=10, b=00, aluop=01, result_src=00. `pc_write` = taken, where:
    - funct3 000 (beq): `zero`.
    - 001 (bne): `!zero`.
    - 100 (blt): `lt`.
    - 101 (bge): `!lt`.
    - Any other funct3: 0.
    - Go to FETCH.
  - LUI: result_src=11, `reg_write`=1. Go to FETCH.
  - TRAP: `illegal`=1 and all other outputs 0. Stays in TRAP until reset.
- `instret` increments by 1, wrapping modulo 2^`INSTRET_W`, on every transition into FETCH from a non-FETCH state. TRAP never increments it.

## Timing
- Reset: while `rst_n` is sampled low at a clock edge:
  - state becomes FETCH and `instret` becomes 0.
  - In the cycle `rst_n` is low, all outputs are forced to 0, including `mem_req`.
  - Reset overrides any state mid-instruction, including an outstanding memory wait.
- Fetch starts the first cycle after `rst_n` goes high.
- Cycles per instruction with `mem_ready` high, counting from the first FETCH cycle:
  - LUI and branch: 3.
  - R-type, I-type, store and JAL: 4.
  - Load and JALR: 5.
- Each cycle `mem_ready` is low in FETCH, MEM_READ or MEM_WRITE adds one cycle. Request outputs stay stable while waiting.
- `mem_ready` outside those three states is ignored.
- `instret` is updated at the same edge that enters FETCH.

## Structure
- Package `multicycle_pkg` holds:
  - the state enum (14 states);
  - opcode constants;
  - `aluop` codes;
  - `alu_src_a`, `alu_src_b`, `result_src` and `imm_src` encodings.
- One sub-module, `branch_cond`: combinational funct3/`zero`/`lt` to taken.
- State register, next-state logic and output decoder live in the top module.

## Test plan
- Reset mid-instruction: hold `rst_n`=0 during MEM_READ. All outputs are 0 and `instret`=0; FETCH starts the cycle after release.
- `add` (opcode 0110011) with `mem_ready` always 1: states FETCH, DECODE, EXEC_R, ALU_WB in 4 cycles; aluop=10 in EXEC_R; `reg_write` for exactly 1 cycle; `instret` goes 0 to 1.
- `lw` with `mem_ready` low for 3 cycles in MEM_READ: total 8 cycles; `mem_req`=1 and `adr_src`=1 held throughout the wait; result_src=01 in MEM_WB.
- `bne`, funct3=001:
  - `zero`=0: `pc_write`=1 in BRANCH, aluop=01.
  - `zero`=1: `pc_write`=0.
  - funct3=010 with `zero`=0: `pc_write`=0.
- `jalr` then `jal`: `pc_write` asserts in the JAL state for both; `reg_write` asserts in ALU_WB; 5 and 4 cycles respectively.
- Opcode 1111111: DECODE goes to TRAP, `illegal`=1 held for 20 cycles, `instret` unchanged; `rst_n` pulse recovers to FETCH.
